uart_hex_display: RTL

UART_HEX_DISPLAY -- requirements
Module: uart_hex_display

---
 rtl/uart_hex_display.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/uart_hex_display.sv
// UART 8N1 receiver feeding a seven-segment hex display buffer.
// MODE 0 shows raw received bytes; MODE 1 treats bytes as typed ASCII hex digits.
module uart_hex_display #(
    parameter int unsigned CLKS_PER_BIT   = 217,
    parameter int unsigned N_DIGITS       = 2,
    parameter int unsigned MODE           = 0,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [7:0]            data,
    output logic                  valid,
    output logic                  frame_err,
    output logic [7*N_DIGITS-1:0] seg
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BW = 4 * N_DIGITS;
    localparam int unsigned SW = 7 * N_DIGITS;

    localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_END = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [6:0]    SEG_ZERO = SEG_ACTIVE_LOW ? 7'b0000001 : 7'b1111110;
    localparam logic [7:0]    ESC      = 8'h1B;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_meta_q, rxs_q, rxs_prev_q;
    logic [BW-1:0] disp_q, disp_d;
    logic [SW-1:0] seg_q, seg_d;
    logic [4:0]    ascii_nib;

    // Active-high segment pattern, A at bit 6 through G at bit 0.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        unique case (nib)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b0011111;
            4'hC: s = 7'b1001110;
            4'hD: s = 7'b0111101;
            4'hE: s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Returns {is_hex_digit, nibble}.
    function automatic logic [4:0] ascii_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0;
        if (c >= 8'h30 && c <= 8'h39) begin
            r = {1'b1, c[3:0]};
        end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
            r = {1'b1, c[3:0] + 4'd9};
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q  <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            rx_meta_q  <= rx;
            rxs_q      <= rx_meta_q;
            rxs_prev_q <= rxs_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q + TW'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                // Only a genuine high-to-low edge starts a frame.
                if (rxs_prev_q && !rxs_q) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (timer_q == HALF_END) begin
                    timer_d   = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? StIdle : StData;
                end
            end
            StData: begin
                if (timer_q == BIT_END) begin
                    timer_d   = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end
                end
            end
            default: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    state_d = StIdle;
                    if (rxs_q) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        disp_d    = disp_q;
        ascii_nib = ascii_to_nibble(data_q);
        if (valid_q) begin
            if (MODE == 0) begin
                disp_d = (disp_q << 8) | BW'(data_q);
            end else if (data_q == ESC) begin
                disp_d = '0;
            end else if (ascii_nib[4]) begin
                disp_d = (disp_q << 4) | BW'(ascii_nib[3:0]);
            end
        end
    end

    always_comb begin
        seg_d = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            seg_d[7*k +: 7] = hex_to_seg(disp_q[4*k +: 4]) ^ {7{SEG_ACTIVE_LOW}};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q <= '0;
            seg_q  <= {N_DIGITS{SEG_ZERO}};
        end else begin
            disp_q <= disp_d;
            seg_q  <= seg_d;
        end
    end

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign seg       = seg_q;

endmodule
